// File: rtl/fc_l2_port_arbiter_if.sv
// Bus bundle between the L2 requesters, the port arbiter and the L2 master port.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface fc_l2_port_arbiter_if #(
  parameter int NB_REQ     = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [NB_REQ-1:0]                 s_req_i;
  logic [NB_REQ-1:0][ADDR_WIDTH-1:0] s_add_i;
  logic [NB_REQ-1:0]                 s_wen_i;
  logic [NB_REQ-1:0][DATA_WIDTH-1:0] s_wdata_i;
  logic [NB_REQ-1:0][BE_WIDTH-1:0]   s_be_i;
  logic [NB_REQ-1:0]                 s_gnt_o;
  logic [NB_REQ-1:0]                 s_r_valid_o;
  logic [DATA_WIDTH-1:0]             s_r_rdata_o;
  logic                              s_r_opc_o;

  logic                  m_req_o;
  logic [ADDR_WIDTH-1:0] m_add_o;
  logic                  m_wen_o;
  logic [DATA_WIDTH-1:0] m_wdata_o;
  logic [BE_WIDTH-1:0]   m_be_o;
  logic                  m_gnt_i;
  logic                  m_r_valid_i;
  logic [DATA_WIDTH-1:0] m_r_rdata_i;
  logic                  m_r_opc_i;

  modport slave (
    input  s_req_i, s_add_i, s_wen_i,
    input  s_wdata_i, s_be_i,
    output s_gnt_o, s_r_valid_o,
    output s_r_rdata_o, s_r_opc_o,
    output m_req_o, m_add_o, m_wen_o,
    output m_wdata_o, m_be_o,
    input  m_gnt_i, m_r_valid_i,
    input  m_r_rdata_i, m_r_opc_i
  );

  modport master (
    output s_req_i, s_add_i, s_wen_i,
    output s_wdata_i, s_be_i,
    input  s_gnt_o, s_r_valid_o,
    input  s_r_rdata_o, s_r_opc_o,
    input  m_req_o, m_add_o, m_wen_o,
    input  m_wdata_o, m_be_o,
    output m_gnt_i, m_r_valid_i,
    output m_r_rdata_i, m_r_opc_i
  );
endinterface

// File: rtl/fc_l2_port_arbiter.sv
// Round-robin arbiter sharing one L2 TCDM port among NB_REQ requesters.
// An in-order ID FIFO routes each response back to its issuing requester.
module fc_l2_port_arbiter #(
  parameter int NB_REQ          = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  fc_l2_port_arbiter_if.slave bus,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic spurious_rsp_o
);
  localparam int IDW = $clog2(NB_REQ);
  localparam int PW  = $clog2(MAX_OUTSTANDING);
  localparam int CW  = PW + 1;

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] lock_idx_q, lock_idx_d;
  logic           lock_q, lock_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  wptr_q, wptr_d;
  logic [PW-1:0]  rptr_q, rptr_d;
  logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [IDW-1:0] fifo_d [MAX_OUTSTANDING];
  logic           spur_q, spur_d;

  logic [IDW-1:0] sel;
  logic any_req, full, empty;
  logic accept, stall, pop;

  // Pick the winner: a stalled request keeps its slot, else round-robin.
  always_comb begin
    int idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    sel   = rr_ptr_q;
    for (int i = 0; i < NB_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NB_REQ;
      if (!found && bus.s_req_i[idx]) begin
        sel   = IDW'(idx);
        found = 1'b1;
      end
    end
    if (lock_q && bus.s_req_i[lock_idx_q])
      sel = lock_idx_q;
  end

  // Handshake qualifiers; full blocks accept regardless of a same-cycle pop.
  always_comb begin
    any_req = |bus.s_req_i;
    full    = (count_q == CW'(MAX_OUTSTANDING));
    empty   = (count_q == '0);
    accept  = any_req & ~full & bus.m_gnt_i;
    stall   = any_req & ~full & ~bus.m_gnt_i;
    pop     = bus.m_r_valid_i & ~empty;
  end

  // Request mux, grant and response routing.
  always_comb begin
    bus.m_req_o     = any_req & ~full;
    bus.m_add_o     = '0;
    bus.m_wen_o     = 1'b0;
    bus.m_wdata_o   = '0;
    bus.m_be_o      = '0;
    bus.s_gnt_o     = '0;
    bus.s_r_valid_o = '0;
    bus.s_r_rdata_o = bus.m_r_rdata_i;
    bus.s_r_opc_o   = bus.m_r_opc_i;
    if (any_req) begin
      bus.m_add_o   = bus.s_add_i[sel];
      bus.m_wen_o   = bus.s_wen_i[sel];
      bus.m_wdata_o = bus.s_wdata_i[sel];
      bus.m_be_o    = bus.s_be_i[sel];
    end
    if (accept)
      bus.s_gnt_o[sel] = 1'b1;
    if (pop)
      bus.s_r_valid_o[fifo_q[rptr_q]] = 1'b1;
    outstanding_o  = count_q;
    spurious_rsp_o = spur_q;
  end

  // Next-state for pointer, lock, ID FIFO, count and spurious flag.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    fifo_d     = fifo_q;
    spur_d     = spur_q | (bus.m_r_valid_i & empty);
    count_d    = count_q + CW'(accept) - CW'(pop);
    if (lock_q && !bus.s_req_i[lock_idx_q])
      lock_d = 1'b0;
    if (accept) begin
      rr_ptr_d       = IDW'((int'(sel) + 1) % NB_REQ);
      lock_d         = 1'b0;
      fifo_d[wptr_q] = sel;
      wptr_d         = wptr_q + 1'b1;
    end
    if (stall) begin
      lock_d     = 1'b1;
      lock_idx_d = sel;
    end
    if (pop)
      rptr_d = rptr_q + 1'b1;
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      spur_q     <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        fifo_q[i] <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      spur_q     <= spur_d;
      fifo_q     <= fifo_d;
    end
  end
endmodule

// File: tb/tb_fc_l2_port_arbiter.sv
// Directed bench for fc_l2_port_arbiter: routing, round-robin,
// outstanding limit, stall lock, spurious responses and reset.
module tb_fc_l2_port_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] outstanding;
  logic spurious;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fc_l2_port_arbiter_if #(.NB_REQ(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  fc_l2_port_arbiter #(
    .NB_REQ(2), .ADDR_WIDTH(32),
    .DATA_WIDTH(32), .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus.slave),
    .outstanding_o(outstanding),
    .spurious_rsp_o(spurious)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.s_req_i     = '0;
    bus.s_wen_i     = 2'b11;
    bus.m_gnt_i     = 1'b0;
    bus.m_r_valid_i = 1'b0;
    bus.m_r_rdata_i = '0;
    bus.m_r_opc_i   = 1'b0;
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic respond(input string tag, input logic [1:0] exp_v);
    bus.s_req_i     = '0;
    bus.m_r_valid_i = 1'b1;
    #1;
    chk(tag, bus.s_r_valid_o, exp_v);
    tick();
    bus.m_r_valid_i = 1'b0;
  endtask

  initial begin
    logic [1:0] gexp [6];
    idle();
    bus.s_add_i[0]   = 32'hA0;
    bus.s_add_i[1]   = 32'hB0;
    bus.s_wdata_i[0] = 32'h1111_0000;
    bus.s_wdata_i[1] = 32'h1234_5678;
    bus.s_be_i[0]    = 4'hF;
    bus.s_be_i[1]    = 4'hC;
    #2;
    chk("rst_outst", outstanding, 0);
    chk("rst_spur", spurious, 0);
    chk("rst_mreq", bus.m_req_o, 0);
    chk("rst_gnt", bus.s_gnt_o, 0);
    chk("rst_madd", bus.m_add_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // single read from requester 0
    bus.s_req_i = 2'b01;
    bus.m_gnt_i = 1'b1;
    #1;
    chk("t1_gnt", bus.s_gnt_o, 2'b01);
    chk("t1_mreq", bus.m_req_o, 1);
    chk("t1_madd", bus.m_add_o, 32'hA0);
    chk("t1_wen", bus.m_wen_o, 1);
    tick();
    bus.s_req_i = '0;
    #1;
    chk("t1_outst1", outstanding, 1);
    bus.m_r_rdata_i = 32'hDEAD_BEEF;
    bus.m_r_valid_i = 1'b1;
    #1;
    chk("t1_rvalid", bus.s_r_valid_o, 2'b01);
    chk("t1_rdata", bus.s_r_rdata_o, 32'hDEAD_BEEF);
    tick();
    bus.m_r_valid_i = 1'b0;
    chk("t1_outst0", outstanding, 0);

    // write from requester 1 with error response
    bus.s_req_i = 2'b10;
    bus.s_wen_i = 2'b01;
    #1;
    chk("t1w_gnt", bus.s_gnt_o, 2'b10);
    chk("t1w_wen", bus.m_wen_o, 0);
    chk("t1w_wdata", bus.m_wdata_o, 32'h1234_5678);
    chk("t1w_be", bus.m_be_o, 4'hC);
    tick();
    bus.s_wen_i = 2'b11;
    bus.m_r_opc_i = 1'b1;
    respond("t1w_rvalid", 2'b10);
    chk("t1w_opc", bus.s_r_opc_o, 1);
    bus.m_r_opc_i = 1'b0;

    // alternating grants with pipelined responses
    apply_reset();
    for (int k = 0; k < 6; k++)
      gexp[k] = (k % 2 == 0) ? 2'b01 : 2'b10;
    for (int k = 0; k < 6; k++) begin
      bus.s_req_i     = 2'b11;
      bus.m_gnt_i     = 1'b1;
      bus.m_r_valid_i = (k > 0);
      bus.m_r_rdata_i = 32'(k);
      #1;
      chk($sformatf("t2_gnt%0d", k), bus.s_gnt_o, gexp[k]);
      chk($sformatf("t2_add%0d", k), bus.m_add_o,
          (k % 2 == 0) ? 32'hA0 : 32'hB0);
      chk($sformatf("t2_rv%0d", k), bus.s_r_valid_o,
          (k > 0) ? gexp[(k > 0) ? k - 1 : 0] : 2'b00);
      tick();
    end
    respond("t2_rv_last", gexp[5]);
    chk("t2_outst", outstanding, 0);

    // outstanding limit
    bus.m_gnt_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.s_req_i = 2'b11;
      #1;
      chk($sformatf("t3_gnt%0d", k), bus.s_gnt_o, gexp[k]);
      tick();
    end
    chk("t3_full_cnt", outstanding, 4);
    chk("t3_full_mreq", bus.m_req_o, 0);
    chk("t3_full_gnt", bus.s_gnt_o, 0);
    bus.m_r_valid_i = 1'b1;
    #1;
    chk("t3_pop_mreq", bus.m_req_o, 0);
    chk("t3_pop_gnt", bus.s_gnt_o, 0);
    chk("t3_pop_rv", bus.s_r_valid_o, 2'b01);
    tick();
    bus.m_r_valid_i = 1'b0;
    #1;
    chk("t3_cnt3", outstanding, 3);
    chk("t3_regnt", bus.s_gnt_o, 2'b01);
    tick();
    chk("t3_cnt4", outstanding, 4);
    respond("t3_d0", 2'b10);
    respond("t3_d1", 2'b01);
    respond("t3_d2", 2'b10);
    respond("t3_d3", 2'b01);
    chk("t3_cnt0", outstanding, 0);

    // stall lock: rr points at 1, req0 wins alone then holds
    bus.s_req_i = 2'b01;
    bus.m_gnt_i = 1'b0;
    #1;
    chk("t4_mreq", bus.m_req_o, 1);
    chk("t4_gnt0", bus.s_gnt_o, 0);
    chk("t4_add0", bus.m_add_o, 32'hA0);
    tick();
    for (int k = 1; k < 3; k++) begin
      bus.s_req_i = 2'b11;
      #1;
      chk($sformatf("t4_add%0d", k), bus.m_add_o, 32'hA0);
      chk($sformatf("t4_gnt%0d", k), bus.s_gnt_o, 0);
      tick();
    end
    bus.m_gnt_i = 1'b1;
    #1;
    chk("t4_lockgnt", bus.s_gnt_o, 2'b01);
    tick();
    #1;
    chk("t4_nextgnt", bus.s_gnt_o, 2'b10);
    tick();
    bus.m_gnt_i = 1'b0;
    #1;
    chk("t4_rel_add0", bus.m_add_o, 32'hA0);
    tick();
    bus.s_req_i = 2'b10;
    #1;
    chk("t4_rel_add1", bus.m_add_o, 32'hB0);
    bus.m_gnt_i = 1'b1;
    #1;
    chk("t4_rel_gnt", bus.s_gnt_o, 2'b10);
    tick();
    respond("t4_d0", 2'b01);
    respond("t4_d1", 2'b10);
    respond("t4_d2", 2'b10);
    chk("t4_cnt0", outstanding, 0);

    // spurious response
    respond("t5_rv", 2'b00);
    chk("t5_spur", spurious, 1);
    chk("t5_cnt", outstanding, 0);
    tick();
    chk("t5_sticky", spurious, 1);

    // reset mid-operation
    apply_reset();
    chk("t6_spur_clr", spurious, 0);
    bus.s_req_i = 2'b11;
    bus.m_gnt_i = 1'b1;
    tick();
    tick();
    tick();
    idle();
    #1;
    chk("t6_cnt3", outstanding, 3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cnt", outstanding, 0);
    chk("t6_rst_gnt", bus.s_gnt_o, 0);
    tick();
    rst_n = 1'b1;
    #1;
    respond("t6_late_rv", 2'b00);
    chk("t6_late_spur", spurious, 1);
    bus.s_req_i = 2'b11;
    bus.m_gnt_i = 1'b1;
    #1;
    chk("t6_first_gnt", bus.s_gnt_o, 2'b01);
    tick();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fc_l2_port_arbiter.md
Name: fc_l2_port_arbiter

Overview:
- Round-robin arbiter that shares one L2 TCDM data port among NB_REQ requesters inside the fabric-controller subsystem (e.g. core data bus plus debug/auxiliary masters).
- Tracks outstanding transactions in an in-order ID FIFO so that each r_valid/r_rdata/r_opc goes back to the requester that issued it.
- Sits between the requesters and the master port that drives l2_data_master.

Parameters:
- NB_REQ, 2, number of requesters (>=2).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width; BE width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, depth of the response-ID FIFO (power of two, >=2).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- s_req_i  in  NB_REQ  per-requester request.
- s_add_i  in  NB_REQ x ADDR_WIDTH  per-requester address.
- s_wen_i  in  NB_REQ  per-requester write-enable-n (1 = read).
- s_wdata_i  in  NB_REQ x DATA_WIDTH  per-requester write data.
- s_be_i  in  NB_REQ x DATA_WIDTH/8  per-requester byte enables.
- s_gnt_o  out  NB_REQ  per-requester grant.
- s_r_valid_o  out  NB_REQ  per-requester response valid.
- s_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all requesters.
- s_r_opc_o  out  1  response error, broadcast to all requesters.
- m_req_o  out  1  master request.
- m_add_o  out  ADDR_WIDTH  master address.
- m_wen_o  out  1  master write-enable-n.
- m_wdata_o  out  DATA_WIDTH  master write data.
- m_be_o  out  DATA_WIDTH/8  master byte enables.
- m_gnt_i  in  1  master grant.
- m_r_valid_i  in  1  master response valid.
- m_r_rdata_i  in  DATA_WIDTH  master response data.
- m_r_opc_i  in  1  master response error.
- outstanding_o  out  clog2(MAX_OUTSTANDING)+1  current in-flight count.
- spurious_rsp_o  out  1  sticky flag: a response arrived with no transaction outstanding.

Behaviour:
- Reset values: all outputs 0; rr_ptr=0; count=0; lock_q=0; lock_idx=0; FIFO empty; spurious flag 0.
- Arbitration is combinational, zero added latency.
  - sel = first requester with s_req_i set, searching from rr_ptr upward with wrap-around.
  - While lock_q=1 and s_req_i[lock_idx]=1, sel=lock_idx.
- full = (count == MAX_OUTSTANDING).
- m_req_o = |s_req_i & ~full. The m_add/wen/wdata/be outputs mux the selected requester; they are 0 when no request is present.
- s_gnt_o[sel] = m_req_o & m_gnt_i; every other grant bit is 0. No grant is ever issued while full.
- Accept = m_req_o & m_gnt_i. On accept:
  - push sel into the FIFO;
  - rr_ptr <= (sel+1) mod NB_REQ;
  - lock_q <= 0.
- Stall (m_req_o & ~m_gnt_i): lock_q <= 1, lock_idx <= sel.
  - The selection must not change while stalled.
  - If the locked requester drops s_req_i, the lock releases that cycle and arbitration restarts from rr_ptr.
- Response path, same cycle as m_r_valid_i (combinational):
  - s_r_valid_o[fifo_head] = m_r_valid_i & ~empty;
  - s_r_rdata_o = m_r_rdata_i and s_r_opc_o = m_r_opc_i, unconditionally;
  - pop the FIFO.
- Responses are in order; the master port guarantees in-order completion.
- Simultaneous accept and response: push and pop together, count unchanged. Legal even when full only if the accept did not happen; full blocks accept irrespective of the same-cycle pop (no gnt←r_valid path).
- r_valid while empty: no s_r_valid_o asserted, count stays 0, spurious_rsp_o <= 1 until reset.
- count = pushes − pops. It never exceeds MAX_OUTSTANDING and never underflows.
- Asynchronous reset mid-transaction clears the FIFO, count, lock and pointer immediately. Late responses after reset count as spurious.

Test Plan:
- Single requester read: s_req_i=01 with m_gnt_i=1 → s_gnt_o=01 same cycle; later m_r_valid_i=1 with rdata=0xDEADBEEF → s_r_valid_o=01, s_r_rdata_o=0xDEADBEEF, outstanding_o returns to 0.
- Both requesters held high, m_gnt_i=1 for 6 cycles → grants alternate 01,10,01,10,01,10; FIFO order matches; responses route 0,1,0,1,0,1.
- Outstanding limit: MAX_OUTSTANDING=4, no responses, continuous requests → 4 grants, then m_req_o=0 with outstanding_o=4. One response → next cycle one more grant.
- Stall lock: req0 wins with m_gnt_i=0 for 3 cycles while req1 is asserted → m_add_o holds req0's address; grant then goes to req0, and next winner is req1.
- Spurious response: m_r_valid_i=1 with count=0 → no s_r_valid_o, spurious_rsp_o=1 and stays 1.
- Reset mid-operation: 3 outstanding, assert rst_ni=0 → outstanding_o=0, all grants 0, rr_ptr=0. After release, first grant goes to the lowest active requester.
